// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, lane helpers.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR       = 3'd3,
      ST_RMW_WR   = 3'd4
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   // Store funct3 with bit 2 set has no sub-word meaning, so it falls back to a word.
   function automatic lsu_size_t access_size(input logic we, input logic [2:0] f3);
      if (we && f3[2])          return SZ_WORD;
      else if (f3[1:0] == 2'b00) return SZ_BYTE;
      else if (f3[1:0] == 2'b01) return SZ_HALF;
      else                       return SZ_WORD;
   endfunction

   function automatic logic [31:0] lane_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_LB:   return {{24{b[7]}}, b};
         F3_LBU:  return {24'h0, b};
         F3_LH:   return {{16{h[15]}}, h};
         F3_LHU:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [31:0] wdata);
      logic [31:0] m;
      m = word;
      case (f3)
         F3_LB:   m[{lane, 3'b000} +: 8] = wdata[7:0];
         F3_LH:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: m = wdata;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: extends sub-word load data and merges sub-word store data.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   assign load_val = lane_extract(funct3, addr_lo, rword);
   assign merged   = lane_merge(funct3, addr_lo, rword, wdata);

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store initiator for a single-port word memory without byte enables.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_ADDR_W = 7,
   parameter int RDATA_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [2:0]            i_req_funct3,
   input  logic [31:0]           i_req_addr,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [31:0]           o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [MEM_ADDR_W-1:0] o_mem_addr,
   output logic [31:0]           o_mem_data,
   output logic                  o_mem_rw,
   input  logic [31:0]           i_mem_data,
   output logic [2:0]            dbg_state
);

   // Handshake: a request transfers on a rising edge with i_req_valid & o_req_ready;
   // the requester holds all request fields stable until that edge.

   localparam int CNT_W = (RDATA_LAT > 1) ? $clog2(RDATA_LAT) : 1;

   lsu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       req_f3;
   logic [1:0]       req_lo;
   logic [31:0]      req_wdata;
   logic             req_we;

   lsu_size_t        req_size;
   logic [1:0]       eff_lo;
   logic             trap;
   logic [31:0]      load_val;
   logic [31:0]      merged;
   logic             unused_addr_hi;

   assign o_req_ready    = (state == ST_IDLE) && !rst;
   assign dbg_state      = state;
   assign unused_addr_hi = ^i_req_addr[31:MEM_ADDR_W];
   assign req_size       = access_size(i_req_we, i_req_funct3);

   always_comb begin
      eff_lo = i_req_addr[1:0];
      if (req_size == SZ_HALF) eff_lo = {i_req_addr[1], 1'b0};
      if (req_size == SZ_WORD) eff_lo = 2'b00;
   end

`ifdef MISALIGN_TRAP_EN
   assign trap = ((req_size == SZ_HALF) && i_req_addr[0]) ||
                 ((req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   lsu_lane_align u_lane_align (
      .funct3   (req_f3),
      .addr_lo  (req_lo),
      .rword    (i_mem_data),
      .wdata    (req_wdata),
      .load_val (load_val),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         req_f3      <= '0;
         req_lo      <= '0;
         req_wdata   <= '0;
         req_we      <= 1'b0;
         o_mem_rw    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_data  <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         o_rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  req_f3    <= i_req_funct3;
                  req_lo    <= eff_lo;
                  req_wdata <= i_req_wdata;
                  req_we    <= i_req_we;
                  if (trap) begin
                     o_rsp_valid <= 1'b1;
                     o_rsp_err   <= 1'b1;
                     o_rsp_rdata <= '0;
                  end else begin
                     o_mem_addr <= {i_req_addr[MEM_ADDR_W-1:2], eff_lo};
                     if (i_req_we && (req_size == SZ_WORD)) begin
                        o_mem_rw   <= 1'b1;
                        o_mem_data <= i_req_wdata;
                        state      <= ST_WR;
                     end else begin
                        o_mem_rw <= 1'b0;
                        state    <= ST_RD_ISSUE;
                     end
                  end
               end
            end
            ST_RD_ISSUE: begin
               cnt   <= CNT_W'(RDATA_LAT - 1);
               state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (cnt == '0) begin
                  // Sub-word stores only reach here; full-word stores bypass the read.
                  if (req_we) begin
                     o_mem_data <= merged;
                     o_mem_rw   <= 1'b1;
                     state      <= ST_RMW_WR;
                  end else begin
                     o_rsp_valid <= 1'b1;
                     o_rsp_rdata <= load_val;
                     o_rsp_err   <= 1'b0;
                     state       <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WR, ST_RMW_WR: begin
               o_mem_rw    <= 1'b0;
               o_rsp_valid <= 1'b1;
               o_rsp_rdata <= '0;
               o_rsp_err   <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
